// File: rtl/counter_ctrl_pkg.sv
// Shared definitions for the counter run-control sequencer.
// The state encoding is also read by the status and debug logic.
package counter_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2,
    ST_DONE = 2'd3
  } ctrl_state_t;

endpackage

// File: rtl/counter_ctrl_if.sv
// Configuration handshake, run-control and status bundle for counter_ctrl.
// The controller is the slave; software/config logic is the master.
interface counter_ctrl_if #(
  parameter int WIDTH = 5
) ();

  logic             cfg_valid;
  logic             cfg_ready;
  logic [WIDTH-1:0] cfg_limit;
  logic             cfg_periodic;
  logic             start;
  logic             stop;
  logic [WIDTH-1:0] count;
  logic             busy;
  logic             done;

  modport master (
    output cfg_valid, cfg_limit, cfg_periodic, start, stop,
    input  cfg_ready, count, busy, done
  );

  modport slave (
    input  cfg_valid, cfg_limit, cfg_periodic, start, stop,
    output cfg_ready, count, busy, done
  );

endinterface

// File: rtl/counter_ctrl_count_core.sv
// WIDTH-bit count register with a ripple-carry incrementer.
// clr (load zero) has priority over en (increment).
module count_core #(
  parameter int WIDTH = 5
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             en,
  input  logic             clr,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] inc;

  // Explicit half-adder chain; carry-in of 1 gives q+1 modulo 2**WIDTH.
  always_comb begin
    logic c;
    c = 1'b1;
    for (int i = 0; i < WIDTH; i++) begin
      inc[i] = q_q[i] ^ c;
      c      = q_q[i] & c;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      q_q <= '0;
    end else if (clr) begin
      q_q <= '0;
    end else if (en) begin
      q_q <= inc;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/counter_ctrl.sv
// Run-control sequencer for an up-counter: terminal value, start/pause/resume,
// one-shot or auto-reload, and a one-cycle done pulse per terminal event.
module counter_ctrl
  import counter_ctrl_pkg::*;
#(
  parameter int               WIDTH         = 5,
  parameter logic [WIDTH-1:0] DEFAULT_LIMIT = '1
) (
  input  logic          clock,
  input  logic          reset,
  counter_ctrl_if.slave bus
);

  ctrl_state_t      state_q;
  logic [WIDTH-1:0] limit_q;
  logic             periodic_q;
  logic             done_q;
  logic [WIDTH-1:0] count_q;
  logic             core_en;
  logic             core_clr;
  logic             cfg_fire;
  logic             at_limit;

  assign bus.cfg_ready = (state_q == ST_IDLE) || (state_q == ST_DONE);
  assign cfg_fire      = bus.cfg_valid && bus.cfg_ready;
  assign at_limit      = (count_q == limit_q);

  // Counter control: a one-shot terminal asserts neither en nor clr, so count parks at limit.
  always_comb begin
    core_en  = 1'b0;
    core_clr = 1'b0;
    unique case (state_q)
      ST_IDLE, ST_DONE: core_clr = cfg_fire || bus.start;
      ST_RUN: begin
        if (!bus.stop) begin
          if (at_limit) core_clr = periodic_q;
          else          core_en  = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      limit_q    <= DEFAULT_LIMIT;
      periodic_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        ST_IDLE, ST_DONE: begin
          if (cfg_fire) begin
            limit_q    <= bus.cfg_limit;
            periodic_q <= bus.cfg_periodic;
          end
          if (bus.start) state_q <= ST_RUN;
        end
        ST_RUN: begin
          if (bus.stop) begin
            state_q <= ST_HOLD;
          end else if (at_limit) begin
            done_q <= 1'b1;
            if (!periodic_q) state_q <= ST_DONE;
          end
        end
        ST_HOLD: begin
          if (bus.start && !bus.stop) state_q <= ST_RUN;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  count_core #(.WIDTH(WIDTH)) u_core (
    .clock (clock),
    .reset (reset),
    .en    (core_en),
    .clr   (core_clr),
    .q     (count_q)
  );

  assign bus.count = count_q;
  assign bus.busy  = (state_q == ST_RUN) || (state_q == ST_HOLD);
  assign bus.done  = done_q;

endmodule
